// File: rtl/register_file_scoreboard.sv
// Decode-stage register file: N combinational read ports, a primary and an R0 write port,
// optional write-to-read bypass, and a per-register busy scoreboard feeding the hazard unit.
module register_file_scoreboard #(
  parameter int unsigned          DATA_W     = 16,
  parameter int unsigned          NUM_REGS   = 16,
  parameter int unsigned          ADDR_W     = 4,
  parameter int unsigned          READ_PORTS = 2,
  parameter int unsigned          BYPASS     = 1,
  parameter logic [DATA_W-1:0]    RESET_VAL  = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [READ_PORTS*ADDR_W-1:0]   read_reg,
  output logic [READ_PORTS*DATA_W-1:0]   read_data,
  output logic [READ_PORTS-1:0]          read_busy,
  input  logic                           reg_write,
  input  logic [ADDR_W-1:0]              write_reg,
  input  logic [DATA_W-1:0]              write_data,
  input  logic                           write_r0,
  input  logic [DATA_W-1:0]              r0,
  input  logic                           issue_en,
  input  logic [ADDR_W-1:0]              issue_reg,
  input  logic                           issue_r0,
  output logic                           busy_any
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr;

  logic pw_en;
  logic r0_en;
  logic iss_en;
  logic iss_r0_en;

  // Reset gates every enable so nothing leaks onto the bypass path while reset is held.
  assign pw_en     = reg_write & ~reset;
  assign r0_en     = write_r0  & ~reset;
  assign iss_en    = issue_en  & ~reset;
  assign iss_r0_en = issue_r0  & ~reset;

  // Addresses beyond NUM_REGS never match a loop index, so they are dropped naturally.
  // Statement order encodes priority: R0 port over primary, and set over clear.
  always_comb begin
    clr    = '0;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (pw_en && (write_reg == ADDR_W'(i))) begin
        regs_d[i] = write_data;
        clr[i]    = 1'b1;
      end
      if (r0_en && (i == 0)) begin
        regs_d[i] = r0;
        clr[i]    = 1'b1;
      end
      if (clr[i]) begin
        busy_d[i] = 1'b0;
      end
      if (iss_en && (issue_reg == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
      if (iss_r0_en && (i == 0)) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // With bypass, regs_d already holds the winning same-cycle write, and a register
  // being cleared this cycle reads as not busy because its value is already forwarded.
  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (read_reg[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          read_data[k*DATA_W +: DATA_W] = (BYPASS != 0) ? regs_d[i] : regs_q[i];
          read_busy[k] = busy_q[i] & ~((BYPASS != 0) & clr[i]);
        end
      end
    end
  end

  assign busy_any = |busy_q;

endmodule
